// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: datapath width, ResultSrc encodings,
// MEM-stage FSM state encoding and the MEM/WB register layout.
package mem_access_stage_pkg;

   localparam int unsigned XLEN = 64;

   // ResultSrc encodings used by the writeback result mux
   localparam logic [1:0] SRC_ALU = 2'b00;
   localparam logic [1:0] SRC_MEM = 2'b01;
   localparam logic [1:0] SRC_PC4 = 2'b10;
   localparam logic [1:0] SRC_IMM = 2'b11;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_RSP = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic            reg_write;
      logic [1:0]      result_src;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] read_data;
      logic [XLEN-1:0] pc_plus4;
      logic [4:0]      rd;
      logic [XLEN-1:0] ext_imm;
   } mem_wb_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory valid/ready port.
//   master (MEM stage): drives req_valid/we/addr/wdata, receives ready and response
//   slave  (memory)   : the reverse
interface mem_access_stage_if;
   import mem_access_stage_pkg::*;

   logic            dmem_req_valid;
   logic            dmem_req_ready;
   logic            dmem_req_we;
   logic [XLEN-1:0] dmem_req_addr;
   logic [XLEN-1:0] dmem_req_wdata;
   logic            dmem_rsp_valid;
   logic [XLEN-1:0] dmem_rsp_rdata;

   modport master (
      output dmem_req_valid,
      input  dmem_req_ready,
      output dmem_req_we,
      output dmem_req_addr,
      output dmem_req_wdata,
      input  dmem_rsp_valid,
      input  dmem_rsp_rdata
   );

   modport slave (
      input  dmem_req_valid,
      output dmem_req_ready,
      input  dmem_req_we,
      input  dmem_req_addr,
      input  dmem_req_wdata,
      output dmem_rsp_valid,
      output dmem_rsp_rdata
   );

endinterface

// File: rtl/mem_access_stage_reglayer_four.sv
// MEM/WB pipeline register.
//   clk, rst : clock, asynchronous active-high reset (clears every field)
//   load     : 1 = capture d, 0 = insert a bubble (reg_write/result_src cleared, rest held)
//   d, q     : MEM/WB fields in / out
module reglayer_four
   import mem_access_stage_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    load,
   input  mem_wb_t d,
   output mem_wb_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else begin
         // Bubble: WB sees no write; data fields hold so nothing toggles needlessly
         q.reg_write  <= 1'b0;
         q.result_src <= SRC_ALU;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage. Issues loads/stores as doubleword transactions on a
// valid/ready data-memory port, stalls upstream while a transaction is
// outstanding and holds the MEM/WB register.
//   clk, rst          : clock, asynchronous active-high reset
//   *M inputs         : EX/MEM register fields
//   StallM            : combinational stall for PC, IF/ID, ID/EX, EX/MEM
//   dmem              : data-memory port (master side)
//   *W outputs        : MEM/WB register fields
module mem_access_stage
   import mem_access_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWriteM,
   input  logic              MemWriteM,
   input  logic [1:0]        ResultSrcM,
   input  logic [XLEN-1:0]   ALUResultM,
   input  logic [XLEN-1:0]   WriteDataM,
   input  logic [XLEN-1:0]   PCPlus4M,
   input  logic [4:0]        RdM,
   input  logic [XLEN-1:0]   ExtImmM,
   output logic              StallM,
   mem_access_stage_if.master dmem,
   output logic              RegWriteW,
   output logic [1:0]        ResultSrcW,
   output logic [XLEN-1:0]   ALUResultW,
   output logic [XLEN-1:0]   ReadDataW,
   output logic [XLEN-1:0]   PCPlus4W,
   output logic [4:0]        RdW,
   output logic [XLEN-1:0]   ExtImmW
);

   mem_state_e      state_q, state_d;
   logic            mem_op;
   logic            is_store;
   logic            stall;
   logic            req_valid;
   logic [XLEN-1:0] read_data;
   mem_wb_t         w_d, w_q;

   // A store wins if both the store flag and the load ResultSrc are set
   assign is_store = MemWriteM;
   assign mem_op   = MemWriteM | (ResultSrcM == SRC_MEM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      stall     = 1'b0;
      req_valid = 1'b0;
      read_data = '0;
      case (state_q)
         IDLE: begin
            // A response arriving here is stale and is ignored
            if (mem_op) begin
               req_valid = 1'b1;
               if (!dmem.dmem_req_ready) begin
                  stall = 1'b1;
               end else if (!is_store) begin
                  stall   = 1'b1;
                  state_d = WAIT_RSP;
               end
            end
         end
         WAIT_RSP: begin
            if (dmem.dmem_rsp_valid) begin
               read_data = dmem.dmem_rsp_rdata;
               state_d   = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Keep the port and the stall quiet for as long as reset is held
      if (rst) begin
         stall     = 1'b0;
         req_valid = 1'b0;
      end
   end

   assign StallM              = stall;
   assign dmem.dmem_req_valid = req_valid;
   // Request fields come straight from EX/MEM, which the stall holds stable
   assign dmem.dmem_req_we    = is_store;
   assign dmem.dmem_req_addr  = {ALUResultM[XLEN-1:3], 3'b000};
   assign dmem.dmem_req_wdata = WriteDataM;

   always_comb begin
      w_d            = '0;
      w_d.reg_write  = RegWriteM;
      w_d.result_src = ResultSrcM;
      w_d.alu_result = ALUResultM;
      w_d.read_data  = read_data;
      w_d.pc_plus4   = PCPlus4M;
      w_d.rd         = RdM;
      w_d.ext_imm    = ExtImmM;
   end

   // Any stalled cycle loads a bubble so WB commits each instruction once
   reglayer_four u_mem_wb (
      .clk  (clk),
      .rst  (rst),
      .load (!stall),
      .d    (w_d),
      .q    (w_q)
   );

   assign RegWriteW  = w_q.reg_write;
   assign ResultSrcW = w_q.result_src;
   assign ALUResultW = w_q.alu_result;
   assign ReadDataW  = w_q.read_data;
   assign PCPlus4W   = w_q.pc_plus4;
   assign RdW        = w_q.rd;
   assign ExtImmW    = w_q.ext_imm;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage. Inputs change on the
// falling edge; combinational outputs are sampled 1ns later, registered
// outputs 1ns after the rising edge.
module tb_mem_access_stage;
   import mem_access_stage_pkg::*;

   logic            clk;
   logic            rst;
   logic            RegWriteM, MemWriteM;
   logic [1:0]      ResultSrcM;
   logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M, ExtImmM;
   logic [4:0]      RdM;
   logic            StallM;
   logic            RegWriteW;
   logic [1:0]      ResultSrcW;
   logic [XLEN-1:0] ALUResultW, ReadDataW, PCPlus4W, ExtImmW;
   logic [4:0]      RdW;

   int tests;
   int fails;

   mem_access_stage_if dmem_bus ();

   mem_access_stage dut (
      .clk        (clk),
      .rst        (rst),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .PCPlus4M   (PCPlus4M),
      .RdM        (RdM),
      .ExtImmM    (ExtImmM),
      .StallM     (StallM),
      .dmem       (dmem_bus.master),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .PCPlus4W   (PCPlus4W),
      .RdW        (RdW),
      .ExtImmW    (ExtImmW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required $finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic set_nop();
      RegWriteM  = 1'b0;
      MemWriteM  = 1'b0;
      ResultSrcM = SRC_ALU;
      ALUResultM = '0;
      WriteDataM = '0;
      PCPlus4M   = '0;
      RdM        = '0;
      ExtImmM    = '0;
   endtask

   task automatic set_load(input logic [XLEN-1:0] addr, input logic [4:0] rd);
      RegWriteM  = 1'b1;
      MemWriteM  = 1'b0;
      ResultSrcM = SRC_MEM;
      ALUResultM = addr;
      WriteDataM = '0;
      PCPlus4M   = addr + 64'h4;
      RdM        = rd;
      ExtImmM    = '0;
   endtask

   task automatic test_reset();
      set_nop();
      dmem_bus.dmem_req_ready = 1'b0;
      dmem_bus.dmem_rsp_valid = 1'b0;
      dmem_bus.dmem_rsp_rdata = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if (RegWriteW !== 1'b0 || RdW !== 5'd0 || ALUResultW !== 64'h0 || ReadDataW !== 64'h0) begin
         fails++;
         $display("FAIL reset_w: RegWriteW=%b RdW=%0d ALUResultW=%h ReadDataW=%h, required all 0",
                  RegWriteW, RdW, ALUResultW, ReadDataW);
      end
      tests++;
      if (StallM !== 1'b0 || dmem_bus.dmem_req_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctl: StallM=%b req_valid=%b, required 0 0",
                  StallM, dmem_bus.dmem_req_valid);
      end
      rst = 1'b0;
   endtask

   task automatic test_alu();
      @(negedge clk);
      set_nop();
      RegWriteM  = 1'b1;
      ALUResultM = 64'h10;
      RdM        = 5'd5;
      PCPlus4M   = 64'h84;
      #1;
      tests++;
      if (StallM !== 1'b0 || dmem_bus.dmem_req_valid !== 1'b0) begin
         fails++;
         $display("FAIL alu_ctl: StallM=%b req_valid=%b, required 0 0",
                  StallM, dmem_bus.dmem_req_valid);
      end
      @(posedge clk);
      #1;
      tests++;
      if (RegWriteW !== 1'b1 || RdW !== 5'd5 || ALUResultW !== 64'h10 || PCPlus4W !== 64'h84
          || ReadDataW !== 64'h0) begin
         fails++;
         $display("FAIL alu_w: RegWriteW=%b RdW=%0d ALUResultW=%h PCPlus4W=%h ReadDataW=%h, required 1 5 10 84 0",
                  RegWriteW, RdW, ALUResultW, PCPlus4W, ReadDataW);
      end
      // x0 destination passes through unchanged
      @(negedge clk);
      RdM        = 5'd0;
      ResultSrcM = SRC_IMM;
      ExtImmM    = 64'hABC;
      #1;
      tests++;
      if (StallM !== 1'b0) begin
         fails++;
         $display("FAIL x0_stall: StallM=%b, required 0", StallM);
      end
      @(posedge clk);
      #1;
      tests++;
      if (RegWriteW !== 1'b1 || RdW !== 5'd0 || ResultSrcW !== SRC_IMM || ExtImmW !== 64'hABC) begin
         fails++;
         $display("FAIL x0_w: RegWriteW=%b RdW=%0d ResultSrcW=%b ExtImmW=%h, required 1 0 11 abc",
                  RegWriteW, RdW, ResultSrcW, ExtImmW);
      end
   endtask

   task automatic test_store();
      @(negedge clk);
      set_nop();
      MemWriteM  = 1'b1;
      ALUResultM = 64'h1003;
      WriteDataM = 64'hDEAD;
      dmem_bus.dmem_req_ready = 1'b1;
      #1;
      tests++;
      if (dmem_bus.dmem_req_valid !== 1'b1 || dmem_bus.dmem_req_we !== 1'b1
          || dmem_bus.dmem_req_addr !== 64'h1000 || dmem_bus.dmem_req_wdata !== 64'hDEAD) begin
         fails++;
         $display("FAIL store_req: valid=%b we=%b addr=%h wdata=%h, required 1 1 1000 dead",
                  dmem_bus.dmem_req_valid, dmem_bus.dmem_req_we, dmem_bus.dmem_req_addr,
                  dmem_bus.dmem_req_wdata);
      end
      tests++;
      if (StallM !== 1'b0) begin
         fails++;
         $display("FAIL store_stall: StallM=%b, required 0", StallM);
      end
      @(posedge clk);
      #1;
      // Captured (not a bubble): ALUResultW shows the store address
      tests++;
      if (RegWriteW !== 1'b0 || ALUResultW !== 64'h1003 || ReadDataW !== 64'h0) begin
         fails++;
         $display("FAIL store_w: RegWriteW=%b ALUResultW=%h ReadDataW=%h, required 0 1003 0",
                  RegWriteW, ALUResultW, ReadDataW);
      end
      @(negedge clk);
      set_nop();
   endtask

   task automatic test_load();
      int reqs = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 0) begin
            set_load(64'h2000, 5'd7);
            dmem_bus.dmem_req_ready = 1'b1;
         end
         #1;
         if (dmem_bus.dmem_req_valid === 1'b1) reqs++;
         tests++;
         if (StallM !== 1'b1) begin
            fails++;
            $display("FAIL load_stall%0d: StallM=%b, required 1", i, StallM);
         end
         if (i == 0) begin
            tests++;
            if (dmem_bus.dmem_req_we !== 1'b0 || dmem_bus.dmem_req_addr !== 64'h2000) begin
               fails++;
               $display("FAIL load_req: we=%b addr=%h, required 0 2000",
                        dmem_bus.dmem_req_we, dmem_bus.dmem_req_addr);
            end
         end
         @(posedge clk);
         #1;
         tests++;
         if (RegWriteW !== 1'b0) begin
            fails++;
            $display("FAIL load_bubble%0d: RegWriteW=%b, required 0", i, RegWriteW);
         end
      end
      @(negedge clk);
      dmem_bus.dmem_rsp_valid = 1'b1;
      dmem_bus.dmem_rsp_rdata = 64'h1234;
      #1;
      if (dmem_bus.dmem_req_valid === 1'b1) reqs++;
      tests++;
      if (StallM !== 1'b0) begin
         fails++;
         $display("FAIL load_rsp_stall: StallM=%b, required 0", StallM);
      end
      tests++;
      if (reqs != 1) begin
         fails++;
         $display("FAIL load_req_count: %0d cycles with req_valid, required 1", reqs);
      end
      @(posedge clk);
      #1;
      tests++;
      if (ReadDataW !== 64'h1234 || RegWriteW !== 1'b1 || RdW !== 5'd7 || ResultSrcW !== SRC_MEM) begin
         fails++;
         $display("FAIL load_w: ReadDataW=%h RegWriteW=%b RdW=%0d ResultSrcW=%b, required 1234 1 7 01",
                  ReadDataW, RegWriteW, RdW, ResultSrcW);
      end
      @(negedge clk);
      dmem_bus.dmem_rsp_valid = 1'b0;
      set_nop();
   endtask

   task automatic test_not_ready();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (i == 0) begin
            set_load(64'h3005, 5'd3);
            dmem_bus.dmem_req_ready = 1'b0;
         end
         #1;
         tests++;
         if (dmem_bus.dmem_req_valid !== 1'b1 || dmem_bus.dmem_req_addr !== 64'h3000
             || StallM !== 1'b1) begin
            fails++;
            $display("FAIL nr_hold%0d: valid=%b addr=%h StallM=%b, required 1 3000 1",
                     i, dmem_bus.dmem_req_valid, dmem_bus.dmem_req_addr, StallM);
         end
         @(posedge clk);
         #1;
         tests++;
         if (RegWriteW !== 1'b0) begin
            fails++;
            $display("FAIL nr_bubble%0d: RegWriteW=%b, required 0", i, RegWriteW);
         end
      end
      @(negedge clk);
      dmem_bus.dmem_req_ready = 1'b1;
      #1;
      tests++;
      if (dmem_bus.dmem_req_valid !== 1'b1 || StallM !== 1'b1) begin
         fails++;
         $display("FAIL nr_accept: valid=%b StallM=%b, required 1 1",
                  dmem_bus.dmem_req_valid, StallM);
      end
      @(negedge clk);
      dmem_bus.dmem_rsp_valid = 1'b1;
      dmem_bus.dmem_rsp_rdata = 64'h5A5A;
      #1;
      tests++;
      if (dmem_bus.dmem_req_valid !== 1'b0 || StallM !== 1'b0) begin
         fails++;
         $display("FAIL nr_rsp: valid=%b StallM=%b, required 0 0",
                  dmem_bus.dmem_req_valid, StallM);
      end
      @(posedge clk);
      #1;
      tests++;
      if (ReadDataW !== 64'h5A5A || RdW !== 5'd3 || RegWriteW !== 1'b1) begin
         fails++;
         $display("FAIL nr_w: ReadDataW=%h RdW=%0d RegWriteW=%b, required 5a5a 3 1",
                  ReadDataW, RdW, RegWriteW);
      end
      @(negedge clk);
      dmem_bus.dmem_rsp_valid = 1'b0;
      set_nop();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      set_load(64'h4000, 5'd9);
      dmem_bus.dmem_req_ready = 1'b1;
      @(posedge clk);
      // Now waiting for the response; assert reset between edges
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (RegWriteW !== 1'b0 || ALUResultW !== 64'h0 || ReadDataW !== 64'h0 || StallM !== 1'b0
          || dmem_bus.dmem_req_valid !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid: RegWriteW=%b ALUResultW=%h ReadDataW=%h StallM=%b valid=%b, required all 0",
                  RegWriteW, ALUResultW, ReadDataW, StallM, dmem_bus.dmem_req_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      set_nop();
      dmem_bus.dmem_rsp_valid = 1'b1;
      dmem_bus.dmem_rsp_rdata = 64'hBEEF;
      #1;
      tests++;
      if (StallM !== 1'b0) begin
         fails++;
         $display("FAIL stale_stall: StallM=%b, required 0", StallM);
      end
      @(posedge clk);
      #1;
      tests++;
      if (ReadDataW !== 64'h0 || RegWriteW !== 1'b0) begin
         fails++;
         $display("FAIL stale_w: ReadDataW=%h RegWriteW=%b, required 0 0", ReadDataW, RegWriteW);
      end
      @(negedge clk);
      dmem_bus.dmem_rsp_valid = 1'b0;
      RegWriteM  = 1'b1;
      RdM        = 5'd4;
      ALUResultM = 64'h44;
      #1;
      // Still idle: an ALU op flows straight through
      tests++;
      if (StallM !== 1'b0) begin
         fails++;
         $display("FAIL stale_state: StallM=%b, required 0", StallM);
      end
      @(posedge clk);
      #1;
      tests++;
      if (RdW !== 5'd4 || ALUResultW !== 64'h44 || ReadDataW !== 64'h0) begin
         fails++;
         $display("FAIL stale_next: RdW=%0d ALUResultW=%h ReadDataW=%h, required 4 44 0",
                  RdW, ALUResultW, ReadDataW);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      set_load(64'h6000, 5'd8);
      dmem_bus.dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_bus.dmem_rsp_valid = 1'b1;
      dmem_bus.dmem_rsp_rdata = 64'h7777;
      @(posedge clk);
      #1;
      tests++;
      if (RdW !== 5'd8 || ReadDataW !== 64'h7777 || RegWriteW !== 1'b1) begin
         fails++;
         $display("FAIL b2b_load: RdW=%0d ReadDataW=%h RegWriteW=%b, required 8 7777 1",
                  RdW, ReadDataW, RegWriteW);
      end
      @(negedge clk);
      dmem_bus.dmem_rsp_valid = 1'b0;
      set_nop();
      RegWriteM  = 1'b1;
      RdM        = 5'd9;
      ALUResultM = 64'h55;
      #1;
      tests++;
      if (StallM !== 1'b0) begin
         fails++;
         $display("FAIL b2b_stall: StallM=%b, required 0", StallM);
      end
      @(posedge clk);
      #1;
      tests++;
      if (RdW !== 5'd9 || ALUResultW !== 64'h55 || ReadDataW !== 64'h0 || RegWriteW !== 1'b1) begin
         fails++;
         $display("FAIL b2b_alu: RdW=%0d ALUResultW=%h ReadDataW=%h RegWriteW=%b, required 9 55 0 1",
                  RdW, ALUResultW, ReadDataW, RegWriteW);
      end
      @(negedge clk);
      set_nop();
      @(posedge clk);
      #1;
      tests++;
      if (RegWriteW !== 1'b0) begin
         fails++;
         $display("FAIL b2b_nop: RegWriteW=%b, required 0", RegWriteW);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_alu();
      test_store();
      test_load();
      test_not_ready();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
